// File: rtl/tpu_pkg.sv
// Shared constants and types for the 4x4 output-stationary systolic array and its sequencer.
package tpu_pkg;

  localparam int unsigned N            = 4;
  localparam int unsigned DATA_SIZE    = 8;
  localparam int unsigned ACC_W        = 2 * DATA_SIZE;
  localparam int unsigned DRAIN_CYCLES = 2 * N + 1;

  typedef enum logic [1:0] {
    IDLE,
    FEED,
    DRAIN,
    WRITE
  } ctrl_state_t;

endpackage

// File: rtl/systolic_ctrl_skew.sv
// One lane of the diagonal input skew: a DEPTH-stage register delay line with synchronous clear.
module skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] pipe_q;

  // NOTE: every stage is cleared, not just the head, so a reset mid-tile cannot leak stale operands into the array.
  always_ff @(posedge clk) begin
    if (clr_i) pipe_q[0] <= '0;
    else       pipe_q[0] <= d_i;
  end

  for (genvar s = 1; s < DEPTH; s++) begin : g_stage
    always_ff @(posedge clk) begin
      if (clr_i) pipe_q[s] <= '0;
      else       pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/systolic_ctrl.sv
// Tile sequencer: reads K operand columns/rows, skews them into the array, drains the
// wavefront, then returns the 16 accumulators as four row beats on a valid/ready port.
module systolic_ctrl
  import tpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ADDR_W:0]        k_len,
  output logic                   busy,
  output logic                   done,
  output logic                   op_ren,
  output logic [ADDR_W-1:0]      op_addr,
  input  logic [N*DATA_SIZE-1:0] a_rdata,
  input  logic [N*DATA_SIZE-1:0] b_rdata,
  output logic                   arr_clr,
  output logic [N*DATA_SIZE-1:0] arr_a,
  output logic [N*DATA_SIZE-1:0] arr_b,
  input  logic [N*N*ACC_W-1:0]   arr_c,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_row,
  output logic [N*ACC_W-1:0]     out_data
);

  localparam logic [ADDR_W:0] K_MAX      = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] DRAIN_LAST = (ADDR_W + 1)'(DRAIN_CYCLES - 1);

  ctrl_state_t                 state_q, state_d;
  logic [ADDR_W:0]             k_q, k_d, cnt_q, cnt_d, k_eff;
  logic [1:0]                  row_q, row_d;
  logic                        zero_q, zero_d, rd_valid_q;
  logic                        busy_d, done_d, op_ren_d, arr_clr_d, out_valid_d;
  logic [ADDR_W-1:0]           op_addr_d;
  logic [1:0]                  out_row_d;
  logic [N*ACC_W-1:0]          out_data_d;
  logic [N-1:0][N*ACC_W-1:0]   arr_rows;
  logic [N-1:0][DATA_SIZE-1:0] a_lane_in, b_lane_in, a_lane_out, b_lane_out;

  assign k_eff     = (k_len > K_MAX) ? K_MAX : k_len;
  assign arr_rows  = arr_c;
  // SRAM data lines are don't-care outside a read, so gate them to keep idle lanes at zero.
  assign a_lane_in = rd_valid_q ? a_rdata : '0;
  assign b_lane_in = rd_valid_q ? b_rdata : '0;
  assign arr_a     = a_lane_out;
  assign arr_b     = b_lane_out;

  for (genvar i = 0; i < N; i++) begin : g_lane
    skew_line #(.DEPTH(i + 1), .WIDTH(DATA_SIZE)) u_skew_a (
      .clk(clk), .clr_i(rst), .d_i(a_lane_in[i]), .q_o(a_lane_out[i])
    );
    skew_line #(.DEPTH(i + 1), .WIDTH(DATA_SIZE)) u_skew_b (
      .clk(clk), .clr_i(rst), .d_i(b_lane_in[i]), .q_o(b_lane_out[i])
    );
  end

  // NOTE: every variable gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        k_d     = k_eff;
        cnt_d   = '0;
        row_d   = '0;
        zero_d  = (k_eff == '0);
        state_d = (k_eff == '0) ? WRITE : FEED;
      end
      FEED: if (cnt_q == k_q - 1'b1) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      DRAIN: if (cnt_q == DRAIN_LAST) begin
        state_d = WRITE;
        row_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      WRITE: if (out_valid && out_ready) begin
        if (row_q == 2'd3) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          row_d = row_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they leave the block registered.
    busy_d      = (state_d != IDLE);
    op_ren_d    = (state_d == FEED);
    op_addr_d   = (state_d == FEED) ? cnt_d[ADDR_W-1:0] : '0;
    arr_clr_d   = (state_d == IDLE);
    out_valid_d = (state_d == WRITE);
    out_row_d   = (state_d == WRITE) ? row_d : '0;
    out_data_d  = (state_d == WRITE && !zero_d) ? arr_rows[row_d] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      row_q      <= '0;
      zero_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      op_ren     <= 1'b0;
      op_addr    <= '0;
      arr_clr    <= 1'b1;
      out_valid  <= 1'b0;
      out_row    <= '0;
      out_data   <= '0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      row_q      <= row_d;
      zero_q     <= zero_d;
      rd_valid_q <= op_ren;
      busy       <= busy_d;
      done       <= done_d;
      op_ren     <= op_ren_d;
      op_addr    <= op_addr_d;
      arr_clr    <= arr_clr_d;
      out_valid  <= out_valid_d;
      out_row    <= out_row_d;
      out_data   <= out_data_d;
    end
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: SRAM and PE-grid models around the DUT, a matrix-product and
// cycle-schedule reference, and one negedge compare process.
module tb_systolic_ctrl;

  logic         clk = 1'b0;
  logic         rst, start, out_ready;
  logic [8:0]   k_len;
  logic         busy, done, op_ren, arr_clr, out_valid;
  logic [7:0]   op_addr;
  logic [31:0]  a_rdata, b_rdata, arr_a, arr_b;
  logic [255:0] arr_c;
  logic [1:0]   out_row;
  logic [63:0]  out_data;

  always #5 clk = ~clk;

  systolic_ctrl #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .op_ren(op_ren), .op_addr(op_addr),
    .a_rdata(a_rdata), .b_rdata(b_rdata), .arr_clr(arr_clr),
    .arr_a(arr_a), .arr_b(arr_b), .arr_c(arr_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_row(out_row), .out_data(out_data)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Operand SRAMs: one-cycle read latency, junk on the data lines when not reading.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];

  always @(posedge clk) begin
    if (op_ren) begin
      a_rdata <= mem_a[op_addr];
      b_rdata <= mem_b[op_addr];
    end else begin
      a_rdata <= $urandom;
      b_rdata <= $urandom;
    end
  end

  // Output-stationary PE grid: a flows right, b flows down, c accumulates mod 2^16.
  logic [7:0]  pa [4][4];
  logic [7:0]  pb [4][4];
  logic [15:0] pc [4][4];

  function automatic logic [7:0] pe_a(input int i, input int j);
    if (j == 0) return arr_a[8*i +: 8];
    return pa[i][j-1];
  endfunction

  function automatic logic [7:0] pe_b(input int i, input int j);
    if (i == 0) return arr_b[8*j +: 8];
    return pb[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        if (arr_clr) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          pc[i][j] <= '0;
        end else begin
          pa[i][j] <= pe_a(i, j);
          pb[i][j] <= pe_b(i, j);
          pc[i][j] <= pc[i][j] + 16'(pe_a(i, j)) * 16'(pe_b(i, j));
        end
      end
    end
  end

  always_comb begin
    arr_c = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        arr_c[16*(4*i+j) +: 16] = pc[i][j];
  end

  // Reference: C = A*B mod 2^16, plus the cycle schedule counted from the start edge.
  int          keff, w0;
  logic [15:0] exp_c [4][4];

  task automatic build_model(input int k);
    keff = (k > 256) ? 256 : k;
    w0   = (keff == 0) ? 1 : keff + 10;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        int unsigned acc;
        acc = 0;
        for (int kk = 0; kk < keff; kk++)
          acc += int'(mem_a[kk][8*i +: 8]) * int'(mem_b[kk][8*j +: 8]);
        exp_c[i][j] = acc[15:0];
      end
    end
  endtask

  function automatic logic [7:0] exp_lane(input bit is_b, input int lane, input int c);
    int k;
    k = c - 3 - lane;
    if (k >= 0 && k < keff) return is_b ? mem_b[k][8*lane +: 8] : mem_a[k][8*lane +: 8];
    return 8'h00;
  endfunction

  function automatic logic [63:0] exp_row(input int r);
    return {exp_c[r][3], exp_c[r][2], exp_c[r][1], exp_c[r][0]};
  endfunction

  // Ready generator: 0 = always ready, 1 = 1,0,0 repeating, 2 = random.
  int ready_mode = 0;
  int ph = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  bit          tile_on = 0, tile_done = 0, idle_chk = 0;
  int          cyc, phase, m_row, reads, done_seen;
  logic [63:0] cap_row [4];

  always @(negedge clk) begin
    if (tile_on) begin
      cyc++;
      if (op_ren) reads++;
      if (done && done_seen == 0) done_seen = cyc;
      for (int i = 0; i < 4; i++) begin
        check("arr_a_lane", 64'(arr_a[8*i +: 8]), 64'(exp_lane(1'b0, i, cyc)));
        check("arr_b_lane", 64'(arr_b[8*i +: 8]), 64'(exp_lane(1'b1, i, cyc)));
      end
      if (phase == 0 && cyc == w0) phase = 1;
      if (phase == 0) begin
        check("busy_run", 64'(busy), 1);
        check("clr_run", 64'(arr_clr), 0);
        check("valid_run", 64'(out_valid), 0);
        check("done_run", 64'(done), 0);
        check("op_ren", 64'(op_ren), 64'(cyc <= keff));
        if (cyc <= keff) check("op_addr", 64'(op_addr), 64'(cyc - 1));
      end else if (phase == 1) begin
        check("busy_wr", 64'(busy), 1);
        check("valid_wr", 64'(out_valid), 1);
        check("row_wr", 64'(out_row), 64'(m_row));
        check("data_wr", out_data, exp_row(m_row));
        check("done_wr", 64'(done), 0);
        check("ren_wr", 64'(op_ren), 0);
        if (out_ready) begin
          cap_row[m_row] = out_data;
          m_row++;
          if (m_row == 4) phase = 2;
        end
      end else begin
        check("done_pulse", 64'(done), 1);
        check("busy_end", 64'(busy), 0);
        check("valid_end", 64'(out_valid), 0);
        check("clr_end", 64'(arr_clr), 1);
        tile_on   = 0;
        tile_done = 1;
      end
    end else if (idle_chk && !rst) begin
      check("idle_busy", 64'(busy), 0);
      check("idle_done", 64'(done), 0);
      check("idle_ren", 64'(op_ren), 0);
      check("idle_clr", 64'(arr_clr), 1);
      check("idle_valid", 64'(out_valid), 0);
      check("idle_lanes", {arr_a, arr_b}, 64'h0);
    end
  end

  task automatic fill_random();
    for (int k = 0; k < 256; k++) begin
      mem_a[k] = $urandom;
      mem_b[k] = $urandom;
    end
  endtask

  task automatic launch(input int k);
    @(posedge clk);
    #1;
    start = 1'b1;
    k_len = 9'(k);
    @(posedge clk);
    #1;
    start     = 1'b0;
    k_len     = 9'($urandom);
    cyc       = 0;
    phase     = 0;
    m_row     = 0;
    reads     = 0;
    done_seen = 0;
    tile_done = 0;
    tile_on   = 1;
  endtask

  task automatic run_tile(input int k, input int mode, input bit mid_start);
    build_model(k);
    ready_mode = mode;
    launch(k);
    for (int n = 0; n < keff + 200 && !tile_done; n++) begin
      @(posedge clk);
      #1;
      start = mid_start && (cyc == w0 + 1);
    end
    start = 1'b0;
    check("tile_timeout", 64'(tile_done), 1);
    tile_on = 0;
    check("sram_reads", 64'(reads), 64'(keff));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    k_len = '0;
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(done), 0);
    check("rst_ren", 64'(op_ren), 0);
    check("rst_addr", 64'(op_addr), 0);
    check("rst_clr", 64'(arr_clr), 1);
    check("rst_lanes", {arr_a, arr_b}, 64'h0);
    check("rst_valid", 64'(out_valid), 0);
    check("rst_row", 64'(out_row), 0);
    check("rst_data", out_data, 64'h0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    idle_chk = 1;

    // Identity A, B rows 1..16.
    for (int k = 0; k < 4; k++) begin
      mem_a[k] = 32'h1 << (8 * k);
      mem_b[k] = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
    end
    run_tile(4, 0, 0);
    check("id_done_cyc", 64'(done_seen), 18);
    check("id_row0", cap_row[0], 64'h0004_0003_0002_0001);
    check("id_row1", cap_row[1], 64'h0008_0007_0006_0005);
    check("id_row2", cap_row[2], 64'h000C_000B_000A_0009);
    check("id_row3", cap_row[3], 64'h0010_000F_000E_000D);

    // K=1 outer product.
    mem_a[0] = 32'h0403_0201;
    mem_b[0] = 32'h0807_0605;
    run_tile(1, 0, 0);
    check("k1_done_cyc", 64'(done_seen), 15);
    check("k1_row0", cap_row[0], 64'h0008_0007_0006_0005);
    check("k1_row1", cap_row[1], 64'h0010_000E_000C_000A);
    check("k1_row2", cap_row[2], 64'h0018_0015_0012_000F);
    check("k1_row3", cap_row[3], 64'h0020_001C_0018_0014);

    // K=2, all operands 255: wraps to 64514.
    mem_a[0] = '1; mem_a[1] = '1;
    mem_b[0] = '1; mem_b[1] = '1;
    run_tile(2, 0, 0);
    check("sat_row0", cap_row[0], 64'hFC02_FC02_FC02_FC02);
    check("sat_row3", cap_row[3], 64'hFC02_FC02_FC02_FC02);

    // K=0: four zero rows and no reads.
    fill_random();
    run_tile(0, 0, 0);
    check("k0_done_cyc", 64'(done_seen), 5);
    check("k0_row1", cap_row[1], 64'h0);
    check("k0_reads", 64'(reads), 0);

    // Stalled write with a start pulse landing mid-WRITE.
    run_tile(int'($urandom_range(3, 20)), 1, 1);

    // Reset during FEED cycle 3 of a K=8 tile, then a clean K=1 tile.
    build_model(8);
    ready_mode = 0;
    launch(8);
    for (int n = 0; n < 20 && cyc < 2; n++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    tile_on = 0;
    @(negedge clk);
    check("abort_busy", 64'(busy), 0);
    check("abort_clr", 64'(arr_clr), 1);
    fill_random();
    run_tile(1, 0, 0);

    // Randomized tiles with mixed backpressure.
    for (int t = 0; t < 6; t++) begin
      fill_random();
      run_tile(int'($urandom_range(1, 24)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    // k_len above 2^ADDR_W clamps to 256.
    fill_random();
    run_tile(300, 0, 0);
    check("clamp_reads", 64'(reads), 256);
    check("clamp_done_cyc", 64'(done_seen), 270);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/systolic_ctrl.md
# systolic_ctrl

Sequencer for the 4x4 output-stationary systolic array of 8-bit PEs with 16-bit accumulators. On `start`, it:
- streams a K-deep A operand (one 4-element column per cycle) and B operand (one 4-element row per cycle) from two single-port operand SRAMs;
- applies the diagonal input skew the array needs and zero-fills idle lanes;
- waits for the wavefront to drain, then emits the 16 accumulated results as four row beats on a valid/ready port.

It sits between the operand buffers and the array; the array's own `rst` is driven by this block.

## Interface
- `N`, 4: array dimension, fixed to 4 by the array.
- `DATA_SIZE`, 8: operand width; accumulators are 2*DATA_SIZE.
- `ADDR_W`, 8: operand SRAM address width; maximum K = 2^ADDR_W.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin one tile; sampled only in IDLE.
- `k_len` in ADDR_W+1: inner dimension K, sampled with `start`.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last result beat is accepted.
- `op_ren` out 1: read enable shared by the A and B SRAMs.
- `op_addr` out ADDR_W: k index shared by both SRAMs.
- `a_rdata` in N*DATA_SIZE: A column k; lane i = row i. Valid the cycle after `op_ren`.
- `b_rdata` in N*DATA_SIZE: B row k; lane j = column j. Same timing as `a_rdata`.
- `arr_clr` out 1: drives the array `rst` (clears accumulators and forwarding registers).
- `arr_a` out N*DATA_SIZE: lane i drives array a(i+1).
- `arr_b` out N*DATA_SIZE: lane j drives array b(j+1).
- `arr_c` in N*N*2*DATA_SIZE: array c1..c16 packed; c1 at LSBs.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: result beat accepted when high together with `out_valid`.
- `out_row` out 2 bits: row index 0..3 of the current beat.
- `out_data` out N*2*DATA_SIZE: {c(4r+4), c(4r+3), c(4r+2), c(4r+1)}.

## Operation
- States: IDLE, FEED, DRAIN, WRITE. All outputs are registered.
- IDLE:
  - `arr_clr`=1 and all lanes are 0.
  - `start`=1 with `k_len`>0 → FEED. `start`=1 with `k_len`=0 → WRITE, which emits four all-zero rows.
- FEED:
  - Runs exactly K cycles with `op_ren`=1 and `op_addr`=0..K-1, incrementing each cycle; `arr_clr`=0.
  - Transitions to DRAIN after address K-1 is issued.
- DRAIN:
  - Runs exactly 2N+1 = 9 cycles with `op_ren`=0; skew lines shift in zeros.
  - On exit, `arr_c` is final and held stable, because `arr_clr`=0 and the inputs are zero.
- WRITE:
  - Emits rows r=0..3 in order; `out_data` is taken directly from `arr_c`.
  - `out_row` advances only on a handshake. The beat is held stable while `out_ready`=0.
  - After the row-3 handshake → IDLE and `done`=1 for one cycle.
- Skew: data read for index k appears on `arr_a` lane i at read-issue cycle + 2 + i, and on `arr_b` lane j at read-issue cycle + 2 + j. Each lane outputs 0 in any cycle that carries no read data.
- Arithmetic: the array wraps modulo 2^(2*DATA_SIZE). This block does no saturation and no overflow flag.
- `start` while `busy`=1 is ignored; `k_len` is not resampled.
- `rst` mid-operation: returns to IDLE next cycle and flushes the skew lines. Any partial tile is discarded and `done` is not pulsed.
- `k_len` > 2^ADDR_W is clamped to 2^ADDR_W.

## Timing
- Reset values: `busy`=0, `done`=0, `op_ren`=0, `op_addr`=0, `arr_clr`=1, `arr_a`=0, `arr_b`=0, `out_valid`=0, `out_row`=0, `out_data`=0.
- Cycle 0 is the edge that samples `start`:
  - Cycles 1..K: FEED.
  - Cycles K+1..K+9: DRAIN.
  - From K+10: WRITE.
- With `out_ready` held high:
  - `out_valid` is high on cycles K+10..K+13.
  - `done` fires on cycle K+14.
  - `busy` falls on the same cycle as `done`.
- `arr_clr` falls on cycle 1 and rises again on the cycle `done` is asserted.

## Structure
- Package `tpu_pkg`:
  - `N` and `DATA_SIZE` constants;
  - `DRAIN_CYCLES` = 2*N+1;
  - `ctrl_state_t` enum {IDLE, FEED, DRAIN, WRITE}.
- Sub-module `skew_line`, parameterised by `DEPTH` and `WIDTH`, with a synchronous clear. It is instantiated once per A lane and once per B lane, with DEPTH = lane+1.

## Test plan
- Identity: A = I4, B rows = {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16}, K=4 → `out_data` rows equal the B rows; `done` on cycle 18.
- K=1: a=(1,2,3,4), b=(5,6,7,8) → row r = (r+1)*(5,6,7,8); `done` on cycle 15.
- K=2, all operands 255 → every c = 130050 mod 65536 = 64514.
- K=0 → four zero rows, no SRAM reads, `done` on cycle 5.
- `out_ready` toggled 1,0,0,1,… during WRITE → rows 0..3 each emitted exactly once; data is held stable during stalls; a `start` pulsed mid-WRITE is ignored.
- `rst` asserted at FEED cycle 3 of a K=8 tile → `busy`=0 and `arr_clr`=1 next cycle. A following K=1 tile produces correct results with no residue.
